// File: rtl/gpu_rasterizer.sv
// rtl/gpu_rasterizer.sv - pops draw ops from the op FIFO and rasterizes fills/sprite blits into the back framebuffer
package gpu_rasterizer_pkg;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [10:0] width;
        logic [10:0] height;
        logic        color;
        logic        mem_en;
        logic [15:0] mem_addr;
        logic        scale;
    } gpu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_DRAW,
        ST_DRAIN
    } state_t;

endpackage

module gpu_rasterizer
    import gpu_rasterizer_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int FB_ADDR_WIDTH     = 19,
    parameter int SPRITE_ADDR_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ce,
    input  gpu_op_t                      op,
    output logic                         op_rd_en,
    input  logic                         op_empty,
    output logic [SPRITE_ADDR_WIDTH-1:0] sprite_rd_addr,
    input  logic [1:0]                   sprite_rd_data,
    output logic                         fb_wr_en,
    output logic [FB_ADDR_WIDTH-1:0]     fb_wr_addr,
    output logic                         fb_wr_data,
    output logic                         idle
);

    state_t                     r_state;
    gpu_op_t                    r_op;
    logic [10:0]                r_col;
    logic [10:0]                r_row;

    logic                       r_s2_valid;
    logic                       r_s2_in_range;
    logic                       r_s2_mem_en;
    logic                       r_s2_color;
    logic [FB_ADDR_WIDTH-1:0]   r_s2_addr;

    // 12-bit sums so x+col can never wrap back into the visible area.
    logic [11:0]                w_px;
    logic [11:0]                w_py;
    logic                       w_in_range;
    logic [FB_ADDR_WIDTH-1:0]   w_pix_addr;
    logic [10:0]                w_tex_col;
    logic [10:0]                w_tex_row;
    logic [10:0]                w_stride;

    assign w_px       = 12'(r_op.x) + 12'(r_col);
    assign w_py       = 12'(r_op.y) + 12'(r_row);
    assign w_in_range = (w_px < 12'(HOR_ACTIVE_PIXELS)) && (w_py < 12'(VER_ACTIVE_PIXELS));
    assign w_pix_addr = FB_ADDR_WIDTH'(32'(w_py) * 32'(HOR_ACTIVE_PIXELS) + 32'(w_px));

    // With scale=1 each stored texel covers a 2x2 block of destination pixels.
    assign w_tex_col  = r_col >> r_op.scale;
    assign w_tex_row  = r_row >> r_op.scale;
    assign w_stride   = r_op.width >> r_op.scale;

    assign sprite_rd_addr = SPRITE_ADDR_WIDTH'(r_op.mem_addr)
                          + SPRITE_ADDR_WIDTH'(22'(w_tex_row) * 22'(w_stride))
                          + SPRITE_ADDR_WIDTH'(w_tex_col);

    assign op_rd_en   = ce && !rst && !op_empty && ((r_state == ST_IDLE) || (r_state == ST_DRAIN));
    assign fb_wr_en   = ce && !rst && r_s2_valid && r_s2_in_range && (!r_s2_mem_en || sprite_rd_data[1]);
    assign fb_wr_data = r_s2_mem_en ? sprite_rd_data[0] : r_s2_color;
    assign fb_wr_addr = r_s2_addr;
    assign idle       = (r_state == ST_IDLE) && op_empty && !fb_wr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_op          <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_s2_valid    <= 1'b0;
            r_s2_in_range <= 1'b0;
            r_s2_mem_en   <= 1'b0;
            r_s2_color    <= 1'b0;
            r_s2_addr     <= '0;
        end else if (ce) begin
            // Second stage lines up with the sprite ROM's one-cycle read latency.
            r_s2_valid    <= (r_state == ST_DRAW);
            r_s2_in_range <= w_in_range;
            r_s2_mem_en   <= r_op.mem_en;
            r_s2_color    <= r_op.color;
            r_s2_addr     <= w_pix_addr;

            case (r_state)
                ST_IDLE: begin
                    if (!op_empty) r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    r_state <= ST_LATCH;
                end
                ST_LATCH: begin
                    r_op  <= op;
                    r_col <= '0;
                    r_row <= '0;
                    if ((op.width == 11'd0) || (op.height == 11'd0)) r_state <= ST_IDLE;
                    else                                             r_state <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (r_col == r_op.width - 11'd1) begin
                        r_col <= '0;
                        if (r_row == r_op.height - 11'd1) r_state <= ST_DRAIN;
                        else                              r_row   <= r_row + 11'd1;
                    end else begin
                        r_col <= r_col + 11'd1;
                    end
                end
                ST_DRAIN: begin
                    // Popping here lets the next op start without an IDLE bubble.
                    r_state <= op_empty ? ST_IDLE : ST_FETCH;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_rasterizer.sv
// tb/tb_gpu_rasterizer.sv - directed self-checking bench for gpu_rasterizer
module tb_gpu_rasterizer;
    import gpu_rasterizer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce  = 1'b1;
    gpu_op_t     fifo_dout = '0;
    logic        op_rd_en;
    logic        op_empty;
    logic [15:0] sprite_rd_addr;
    logic [1:0]  sprite_rd_data = 2'b00;
    logic        fb_wr_en;
    logic [18:0] fb_wr_addr;
    logic        fb_wr_data;
    logic        idle;

    int checks = 0;
    int errors = 0;

    gpu_op_t     fifo_mem [0:15];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          pop_empty_cnt = 0;
    logic [1:0]  rom [0:255];

    int          cyc = 0;
    int          n_wr = 0;
    int          n_pop = 0;
    int          n_sa = 0;
    int          wr_addr [0:255];
    logic        wr_data [0:255];
    int          wr_cyc  [0:255];
    int          pop_cyc [0:63];
    int          sa_log  [0:255];

    gpu_rasterizer dut (
        .clk            (clk),
        .rst            (rst),
        .ce             (ce),
        .op             (fifo_dout),
        .op_rd_en       (op_rd_en),
        .op_empty       (op_empty),
        .sprite_rd_addr (sprite_rd_addr),
        .sprite_rd_data (sprite_rd_data),
        .fb_wr_en       (fb_wr_en),
        .fb_wr_addr     (fb_wr_addr),
        .fb_wr_data     (fb_wr_data),
        .idle           (idle)
    );

    always #5 clk = ~clk;

    assign op_empty = (wr_ptr == rd_ptr);

    // Standard FIFO read port and synchronous sprite ROM.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (op_rd_en) begin
            if (wr_ptr == rd_ptr) pop_empty_cnt <= pop_empty_cnt + 1;
            else begin
                fifo_dout <= fifo_mem[rd_ptr % 16];
                rd_ptr    <= rd_ptr + 1;
            end
        end
        if (ce) sprite_rd_data <= rom[sprite_rd_addr[7:0]];
    end

    always @(negedge clk) begin
        if (op_rd_en && n_pop < 64) begin
            pop_cyc[n_pop] = cyc;
            n_pop++;
        end
        if (fb_wr_en && n_wr < 256) begin
            wr_addr[n_wr] = int'(fb_wr_addr);
            wr_data[n_wr] = fb_wr_data;
            wr_cyc[n_wr]  = cyc;
            n_wr++;
        end
        if (ce && !rst && dut.r_state == ST_DRAW && n_sa < 256) begin
            sa_log[n_sa] = int'(sprite_rd_addr);
            n_sa++;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input gpu_op_t o);
        fifo_mem[wr_ptr % 16] = o;
        wr_ptr++;
    endtask

    function automatic gpu_op_t mk(input int x, input int y, input int w, input int h,
                                   input bit color, input bit mem_en, input int addr, input bit scale);
        gpu_op_t o;
        o.x = 11'(x);
        o.y = 11'(y);
        o.width = 11'(w);
        o.height = 11'(h);
        o.color = color;
        o.mem_en = mem_en;
        o.mem_addr = 16'(addr);
        o.scale = scale;
        return o;
    endfunction

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!idle && n < 500);
        check(tag, int'(idle), 1);
    endtask

    initial begin
        int bw, bp, bs, b2;
        int exp_a [0:7];
        int exp_d [0:7];
        int exp_s [0:7];

        for (int i = 0; i < 256; i++) rom[i] = 2'b00;
        rom[100] = 2'd3; rom[101] = 2'd2; rom[102] = 2'd1; rom[103] = 2'd3;
        rom[0]   = 2'd3; rom[1]   = 2'd2;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_op_rd_en", int'(op_rd_en), 0);
        check("rst_fb_wr_en", int'(fb_wr_en), 0);
        check("rst_fb_wr_addr", int'(fb_wr_addr), 0);
        check("rst_fb_wr_data", int'(fb_wr_data), 0);
        check("rst_sprite_addr", int'(sprite_rd_addr), 0);
        check("rst_idle", int'(idle), 1);
        sync();
        rst = 1'b0;

        // Solid fill 4x2 at (10,5)
        sync();
        bw = n_wr; bp = n_pop;
        push(mk(10, 5, 4, 2, 1'b1, 1'b0, 0, 1'b0));
        wait_idle("fill_idle");
        check("fill_count", n_wr - bw, 8);
        check("fill_pops", n_pop - bp, 1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("fill_addr%0d", i), wr_addr[bw + i], (i < 4) ? 3210 + i : 3850 + i - 4);
            check($sformatf("fill_data%0d", i), int'(wr_data[bw + i]), 1);
        end
        check("fill_latency", wr_cyc[bw] - pop_cyc[bp], 4);

        // Sprite 2x2, scale 0: texel 102 (=01b) is transparent
        sync();
        bw = n_wr; bs = n_sa;
        push(mk(0, 0, 2, 2, 1'b0, 1'b1, 100, 1'b0));
        wait_idle("spr0_idle");
        check("spr0_count", n_wr - bw, 3);
        exp_a[0] = 0; exp_a[1] = 1; exp_a[2] = 641;
        exp_d[0] = 1; exp_d[1] = 0; exp_d[2] = 1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("spr0_addr%0d", i), wr_addr[bw + i], exp_a[i]);
            check($sformatf("spr0_data%0d", i), int'(wr_data[bw + i]), exp_d[i]);
        end
        check("spr0_sa_count", n_sa - bs, 4);
        for (int i = 0; i < 4; i++) check($sformatf("spr0_sa%0d", i), sa_log[bs + i], 100 + i);

        // Sprite 4x2, scale 1
        sync();
        bw = n_wr; bs = n_sa;
        push(mk(0, 0, 4, 2, 1'b0, 1'b1, 0, 1'b1));
        wait_idle("spr1_idle");
        check("spr1_count", n_wr - bw, 8);
        for (int i = 0; i < 8; i++) begin
            exp_a[i] = (i < 4) ? i : 640 + i - 4;
            exp_d[i] = ((i % 4) < 2) ? 1 : 0;
            exp_s[i] = ((i % 4) < 2) ? 0 : 1;
        end
        check("spr1_sa_count", n_sa - bs, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("spr1_addr%0d", i), wr_addr[bw + i], exp_a[i]);
            check($sformatf("spr1_data%0d", i), int'(wr_data[bw + i]), exp_d[i]);
            check($sformatf("spr1_sa%0d", i), sa_log[bs + i], exp_s[i]);
        end

        // Horizontal clip, vertical clip, zero width
        sync();
        bw = n_wr;
        push(mk(638, 0, 4, 1, 1'b1, 1'b0, 0, 1'b0));
        wait_idle("clip_idle");
        check("clip_count", n_wr - bw, 2);
        check("clip_addr0", wr_addr[bw], 638);
        check("clip_addr1", wr_addr[bw + 1], 639);
        sync();
        bw = n_wr;
        push(mk(0, 480, 1, 1, 1'b1, 1'b0, 0, 1'b0));
        wait_idle("vclip_idle");
        check("vclip_count", n_wr - bw, 0);
        sync();
        bw = n_wr; bp = n_pop;
        push(mk(5, 5, 0, 3, 1'b1, 1'b0, 0, 1'b0));
        wait_idle("zero_idle");
        check("zero_pops", n_pop - bp, 1);
        check("zero_count", n_wr - bw, 0);

        // Back-to-back 1x1 ops with ce toggling every cycle
        sync();
        bw = n_wr; bp = n_pop;
        push(mk(1, 1, 1, 1, 1'b1, 1'b0, 0, 1'b0));
        push(mk(2, 1, 1, 1, 1'b0, 1'b0, 0, 1'b0));
        push(mk(3, 1, 1, 1, 1'b1, 1'b0, 0, 1'b0));
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1 ce = ~ce;
            @(negedge clk);
            if (idle) break;
        end
        check("stall_idle", int'(idle), 1);
        sync();
        ce = 1'b1;
        check("stall_pops", n_pop - bp, 3);
        check("stall_count", n_wr - bw, 3);
        check("stall_pop_empty", pop_empty_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall_addr%0d", i), wr_addr[bw + i], 641 + i);
            check($sformatf("stall_data%0d", i), int'(wr_data[bw + i]), (i == 1) ? 0 : 1);
        end

        // Reset during row 1 of a 10x10 fill, second op waiting in the FIFO
        sync();
        bw = n_wr;
        push(mk(0, 10, 10, 10, 1'b1, 1'b0, 0, 1'b0));
        push(mk(5, 20, 2, 1, 1'b1, 1'b0, 0, 1'b0));
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            if (n_wr - bw >= 12) break;
        end
        check("mid_reached_row1", (n_wr - bw >= 12) ? 1 : 0, 1);
        #1 rst = 1'b1;
        b2 = n_wr;
        @(negedge clk);
        check("mid_rst_wr_en0", int'(fb_wr_en), 0);
        check("mid_rst_rd_en0", int'(op_rd_en), 0);
        sync();
        @(negedge clk);
        check("mid_rst_wr_en1", int'(fb_wr_en), 0);
        sync();
        rst = 1'b0;
        check("mid_rst_no_writes", n_wr - b2, 0);
        b2 = n_wr;
        wait_idle("mid_after_idle");
        check("mid_after_count", n_wr - b2, 2);
        check("mid_after_addr0", wr_addr[b2], 12805);
        check("mid_after_addr1", wr_addr[b2 + 1], 12806);
        check("final_pop_empty", pop_empty_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
